stopwatch_ctrl: RTL

Stopwatch controller driven by the square-wave outputs of the lab frequency divider. It turns the 1 kHz output into a key-debounce timebase and the 100 Hz output into a centisecond count tick. It runs a start/pause/lap/clear state machine and presents a BCD mm:ss.cc count for the seven-segment display driver. All logic runs in the clk_50MHz domain; the divider outputs are treated as asynchronous data, never as clocks.

---
 rtl/stopwatch_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: divider tick extraction, key debounce, start/pause/lap/clear FSM, BCD mm:ss.cc count.
// Optional lap/snapshot feature enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       clk_1KHz,
  input  logic       clk_100Hz,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic       run,
  output logic       lap_hold,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       overflow
);

  localparam int unsigned DBW         = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS + 1);
  localparam logic [3:0]  MAX_MIN_TEN = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_MIN_ONE = 4'(MAX_MIN % 10);

  typedef struct packed {
    logic [3:0] m1, m0, s1, s0, c1, c0;
  } bcd_t;

`ifdef STOPWATCH_CTRL_LAP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

  logic [2:0]          k1_q, h100_q;
  logic [1:0]          ssync_q, lsync_q;
  logic [1:0]          sync_lvl;
  logic [1:0]          stable_q, stable_d;
  logic [1:0][DBW-1:0] dbc_q, dbc_d;
  logic [1:0]          press_q;
  logic                tick_1k, tick_100;
  state_t              state_q, state_d;
  bcd_t                cnt_q, cnt_d, inc, disp_d;
  logic                wrap, ovf_d, start_ev, lap_ev;
`ifdef STOPWATCH_CTRL_LAP_EN
  bcd_t                snap_q, snap_d;
`endif

  assign tick_1k  = k1_q[1] & ~k1_q[2];
  assign tick_100 = h100_q[1] & ~h100_q[2];
  assign sync_lvl = {lsync_q[1], ssync_q[1]};
  assign start_ev = press_q[0];
  assign lap_ev   = press_q[1] & ~press_q[0];

  // Per-key debounce: a new level must persist for DEBOUNCE_MS 1 kHz ticks.
  always_comb begin
    stable_d = stable_q;
    dbc_d    = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync_lvl[k] != stable_q[k]) begin
        dbc_d[k] = dbc_q[k];
        if (tick_1k) begin
          if (dbc_q[k] == DBW'(DEBOUNCE_MS - 1)) begin
            stable_d[k] = sync_lvl[k];
            dbc_d[k]    = '0;
          end else begin
            dbc_d[k] = dbc_q[k] + DBW'(1);
          end
        end
      end
    end
  end

  // Digit-wise BCD increment with wrap after MAX_MIN:59.99.
  always_comb begin
    inc  = cnt_q;
    wrap = 1'b0;
    if (cnt_q.c0 != 4'd9) inc.c0 = cnt_q.c0 + 4'd1;
    else begin
      inc.c0 = 4'd0;
      if (cnt_q.c1 != 4'd9) inc.c1 = cnt_q.c1 + 4'd1;
      else begin
        inc.c1 = 4'd0;
        if (cnt_q.s0 != 4'd9) inc.s0 = cnt_q.s0 + 4'd1;
        else begin
          inc.s0 = 4'd0;
          if (cnt_q.s1 != 4'd5) inc.s1 = cnt_q.s1 + 4'd1;
          else begin
            inc.s1 = 4'd0;
            if (cnt_q.m1 == MAX_MIN_TEN && cnt_q.m0 == MAX_MIN_ONE) begin
              inc.m1 = 4'd0;
              inc.m0 = 4'd0;
              wrap   = 1'b1;
            end else if (cnt_q.m0 != 4'd9) inc.m0 = cnt_q.m0 + 4'd1;
            else begin
              inc.m0 = 4'd0;
              inc.m1 = cnt_q.m1 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Next state, count and display; start wins over a simultaneous lap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = overflow;
`ifdef STOPWATCH_CTRL_LAP_EN
    snap_d  = snap_q;
    if ((state_q == S_RUN || state_q == S_LAP) && tick_100) begin
`else
    if (state_q == S_RUN && tick_100) begin
`endif
      cnt_d = inc;
      if (wrap) ovf_d = 1'b1;
    end
    case (state_q)
      S_IDLE:  if (start_ev) state_d = S_RUN;
      S_RUN: begin
        if (start_ev) state_d = S_PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
        else if (lap_ev) begin
          state_d = S_LAP;
          snap_d  = cnt_q;
        end
`endif
      end
      S_PAUSE: begin
        if (start_ev) state_d = S_RUN;
        else if (lap_ev) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
`ifdef STOPWATCH_CTRL_LAP_EN
      S_LAP: begin
        if (start_ev) state_d = S_PAUSE;
        else if (lap_ev) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    disp_d = cnt_d;
`ifdef STOPWATCH_CTRL_LAP_EN
    if (state_d == S_LAP) disp_d = snap_d;
`endif
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      k1_q     <= '0;
      h100_q   <= '0;
      ssync_q  <= 2'b11;
      lsync_q  <= 2'b11;
      stable_q <= 2'b11;
      dbc_q    <= '0;
      press_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      run      <= 1'b0;
      overflow <= 1'b0;
      cs_bcd   <= '0;
      sec_bcd  <= '0;
      min_bcd  <= '0;
    end else begin
      k1_q     <= {k1_q[1:0], clk_1KHz};
      h100_q   <= {h100_q[1:0], clk_100Hz};
      ssync_q  <= {ssync_q[0], key_start_n};
      lsync_q  <= {lsync_q[0], key_lap_n};
      stable_q <= stable_d;
      dbc_q    <= dbc_d;
      press_q  <= stable_q & ~stable_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`ifdef STOPWATCH_CTRL_LAP_EN
      run      <= (state_d == S_RUN) || (state_d == S_LAP);
`else
      run      <= (state_d == S_RUN);
`endif
      overflow <= ovf_d;
      cs_bcd   <= {disp_d.c1, disp_d.c0};
      sec_bcd  <= {disp_d.s1, disp_d.s0};
      min_bcd  <= {disp_d.m1, disp_d.m0};
    end
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      snap_q   <= '0;
      lap_hold <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      lap_hold <= (state_d == S_LAP);
    end
  end
`else
  assign lap_hold = 1'b0;
`endif

endmodule
